// File: rtl/gsim_pkg.sv
// Shared constants, FSM state type and address helper for the GSIM matrix fetch unit.
package gsim_pkg;

    localparam int LINES_PER_MAT    = 17;
    localparam int FETCH_FIFO_DEPTH = 4;
    localparam int LINE_W           = 256;
    localparam int ADDR_W           = 10;
    localparam int TAG_W            = 5;
    localparam int ENTRY_W          = LINE_W + TAG_W;
    localparam int CNT_W            = $clog2(FETCH_FIFO_DEPTH + 1);
    localparam int PTR_W            = $clog2(FETCH_FIFO_DEPTH);

    localparam logic [TAG_W-1:0] LAST_LINE = TAG_W'(LINES_PER_MAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } fetch_state_e;

    // First line address of a matrix; the largest index still fits in ADDR_W bits.
    function automatic logic [ADDR_W-1:0] matBaseAddr(input logic [4:0] matIdx);
        return ADDR_W'(matIdx) * ADDR_W'(LINES_PER_MAT);
    endfunction

endpackage

// File: rtl/gsim_mem_fetch_if.sv
// Line output bus from the fetch FIFO head towards the GSIM core.
interface gsim_mem_fetch_if;
    import gsim_pkg::*;

    logic              vld;
    logic [LINE_W-1:0] data;
    logic [TAG_W-1:0]  idx;

    modport master (output vld, data, idx);
    modport slave  (input  vld, data, idx);

endinterface

// File: rtl/gsim_line_fifo.sv
// Four-entry line FIFO; each entry holds one memory line plus its line-number tag.
module gsim_line_fifo
    import gsim_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [LINE_W-1:0]  pushData_i,
    input  logic [TAG_W-1:0]   pushTag_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o,
    gsim_mem_fetch_if.master   head
);

    logic [ENTRY_W-1:0] mem_q [FETCH_FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q;
    logic [PTR_W-1:0]   rdPtr_q;
    logic [CNT_W-1:0]   count_q;
    logic [ENTRY_W-1:0] headEntry;
    logic               doPush;
    logic               doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(FETCH_FIFO_DEPTH));
    assign count_o = count_q;

    // A push while full is only legal when the head leaves in the same cycle.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= {pushTag_i, pushData_i};
                wrPtr_q        <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    assign headEntry = mem_q[rdPtr_q];
    assign head.vld  = !empty_o;
    assign head.data = headEntry[LINE_W-1:0];
    assign head.idx  = headEntry[ENTRY_W-1:LINE_W];

endmodule

// File: rtl/gsim_mem_fetch.sv
// Fetches the 17 lines of one GSIM matrix from line memory into a credit-limited FIFO.
// Optional stall counter output is enabled with `define GSIM_FETCH_PERF_EN.
module gsim_mem_fetch
    import gsim_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [4:0]        i_matrix_idx,
    output logic              o_busy,
    output logic              o_mem_rreq,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_rrdy,
    input  logic [LINE_W-1:0] i_mem_dout,
    input  logic              i_mem_dout_vld,
    output logic              o_line_vld,
    output logic [LINE_W-1:0] o_line_data,
    output logic [TAG_W-1:0]  o_line_idx,
    input  logic              i_line_rdy,
    output logic              o_done
`ifdef GSIM_FETCH_PERF_EN
    ,
    output logic [15:0]       o_stall_cnt
`endif
);

    localparam int CREDIT_W = CNT_W + 1;

    fetch_state_e        state_q;
    logic                busy_q;
    logic                rreq_q;
    logic                done_q;
    logic                pendVld_q;
    logic [TAG_W-1:0]    pendTag_q;
    logic [TAG_W-1:0]    reqTag_q;
    logic [TAG_W-1:0]    lineCnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   matBase_q;

    logic                accept;
    logic                push;
    logic                pop;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [CNT_W-1:0]    fifoCount;
    logic [CREDIT_W-1:0] creditNext;
    logic                canIssue;

    gsim_mem_fetch_if lineBus ();

    gsim_line_fifo u_fifo (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .push_i     (push),
        .pushData_i (i_mem_dout),
        .pushTag_i  (pendTag_q),
        .pop_i      (pop),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount),
        .head       (lineBus)
    );

    // Returned data is only taken when a request is actually owed, so stray valids are dropped.
    assign accept = rreq_q && i_mem_rrdy;
    assign push   = pendVld_q && i_mem_dout_vld && (!fifoFull || pop);
    assign pop    = !fifoEmpty && i_line_rdy;

    // Lines that will occupy a FIFO slot next cycle; a new request needs one more free slot.
    assign creditNext = CREDIT_W'(fifoCount) + CREDIT_W'(push) - CREDIT_W'(pop) + CREDIT_W'(accept);
    assign canIssue   = (lineCnt_q < TAG_W'(LINES_PER_MAT)) &&
                        (creditNext < CREDIT_W'(FETCH_FIFO_DEPTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            rreq_q    <= 1'b0;
            done_q    <= 1'b0;
            pendVld_q <= 1'b0;
            pendTag_q <= '0;
            reqTag_q  <= '0;
            lineCnt_q <= '0;
            addr_q    <= '0;
            matBase_q <= '0;
        end else begin
            done_q    <= 1'b0;
            pendVld_q <= accept;
            if (accept) begin
                pendTag_q <= reqTag_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q   <= ST_FETCH;
                        busy_q    <= 1'b1;
                        matBase_q <= matBaseAddr(i_matrix_idx);
                        addr_q    <= matBaseAddr(i_matrix_idx);
                        rreq_q    <= 1'b1;
                        reqTag_q  <= '0;
                        lineCnt_q <= TAG_W'(1);
                    end
                end
                ST_FETCH: begin
                    if (accept && (reqTag_q == LAST_LINE)) begin
                        rreq_q  <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else if (!rreq_q || accept) begin
                        if (canIssue) begin
                            rreq_q    <= 1'b1;
                            addr_q    <= matBase_q + ADDR_W'(lineCnt_q);
                            reqTag_q  <= lineCnt_q;
                            lineCnt_q <= lineCnt_q + TAG_W'(1);
                        end else begin
                            rreq_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && (lineBus.idx == LAST_LINE)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GSIM_FETCH_PERF_EN
    logic [15:0] stallCnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stallCnt_q <= '0;
        end else if ((state_q == ST_IDLE) && i_start) begin
            stallCnt_q <= '0;
        end else if ((state_q == ST_FETCH) && rreq_q && !i_mem_rrdy && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign o_stall_cnt = stallCnt_q;
`endif

    assign o_busy      = busy_q;
    assign o_mem_rreq  = rreq_q;
    assign o_mem_addr  = addr_q;
    assign o_done      = done_q;
    assign o_line_vld  = lineBus.vld;
    assign o_line_data = lineBus.data;
    assign o_line_idx  = lineBus.idx;

endmodule
